crc_checker: RTL and testbench

CRC_CHECKER -- requirements
Module: crc_checker

---
 rtl/crc_pkg.sv | 23 ++
 rtl/crc8_serial.sv | 13 +
 rtl/crc_checker.sv | 155 +++++++++++++++
 tb/tb_crc_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC-8 constants, checker FSM states and the
// single-bit CRC-8 update used by the checker and the generator.
package crc_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  function automatic logic [7:0] crc8_bit(
    input logic       b,
    input logic [7:0] crc
  );
    logic fb;
    fb = b ^ crc[7];
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: combinational next CRC-8 from one serial bit.
// Ports: i_bit (data bit), i_crc (current crc), o_crc (next crc).
module crc8_serial
  import crc_pkg::*;
(
  input  logic       i_bit,
  input  logic [7:0] i_crc,
  output logic [7:0] o_crc
);

  assign o_crc = crc8_bit(i_bit, i_crc);

endmodule

// File: rtl/crc_checker.sv
// crc_checker: serial MSB-first frame receiver, PAYLOAD_BYTES bytes
// then CRC-8 (poly 0x07); pulses byte_valid per payload byte and
// crc_ok/crc_err per frame. Inputs: clk, rst (sync, high), data_in,
// data_valid, frame_start. Outputs: byte_out, byte_valid, crc_ok,
// crc_err, frame_abort, busy; err_count when CRC_CHECKER_ERR_CNT_EN.
module crc_checker
  import crc_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_in,
  input  logic        data_valid,
  input  logic        frame_start,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        frame_abort,
`ifdef CRC_CHECKER_ERR_CNT_EN
  output logic        busy,
  output logic [15:0] err_count
`else
  output logic        busy
`endif
);

  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_crc;
  logic [7:0] r_shift;
  logic [2:0] r_bitpos;
  logic [7:0] r_bytecnt;

  logic       w_start;
  logic       w_accept;
  logic       w_abort;
  logic       w_byte_done;
  logic       w_crc_done;
  logic [7:0] w_crc_in;
  logic [7:0] w_crc_nxt;

  // A start bit restarts from the init value in any state.
  assign w_start  = data_valid & frame_start;
  assign w_crc_in = w_start ? CRC8_INIT : r_crc;

  crc8_serial u_crc (
    .i_bit (data_in),
    .i_crc (w_crc_in),
    .o_crc (w_crc_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_byte_done = 1'b0;
    w_crc_done  = 1'b0;
    if (w_start) begin
      w_abort     = (r_state != IDLE);
      w_accept    = 1'b1;
      w_state_nxt = PAYLOAD;
    end else if (data_valid) begin
      unique case (r_state)
        IDLE: begin
        end
        PAYLOAD: begin
          w_accept = 1'b1;
          if (r_bitpos == 3'd7) begin
            w_byte_done = 1'b1;
            if (r_bytecnt == LAST_BYTE)
              w_state_nxt = CHECK;
          end
        end
        CHECK: begin
          w_accept = 1'b1;
          if (r_bitpos == 3'd7) begin
            w_crc_done  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc       <= CRC8_INIT;
      r_shift     <= 8'h00;
      r_bitpos    <= 3'd0;
      r_bytecnt   <= 8'h00;
      byte_out    <= 8'h00;
      byte_valid  <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      frame_abort <= w_abort;
      if (w_accept) begin
        r_crc <= w_crc_nxt;
        if (w_start) begin
          r_shift  <= {7'b0, data_in};
          r_bitpos <= 3'd1;
        end else begin
          r_shift  <= {r_shift[6:0], data_in};
          // 7 -> 0 wrap lines CHECK up on a byte boundary.
          r_bitpos <= r_bitpos + 3'd1;
        end
      end
      if (w_start)
        r_bytecnt <= 8'h00;
      else if (w_byte_done)
        r_bytecnt <= r_bytecnt + 8'h01;
      if (w_byte_done) begin
        byte_out   <= {r_shift[6:0], data_in};
        byte_valid <= 1'b1;
      end
      // Running the received CRC through the register leaves zero
      // on a good frame.
      if (w_crc_done) begin
        crc_ok  <= (w_crc_nxt == 8'h00);
        crc_err <= (w_crc_nxt != 8'h00);
      end
    end
  end

  assign busy = (r_state != IDLE);

`ifdef CRC_CHECKER_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_err_cnt <= 16'h0000;
    else if (w_crc_done && (w_crc_nxt != 8'h00)
             && (r_err_cnt != 16'hFFFF))
      r_err_cnt <= r_err_cnt + 16'h0001;
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_crc_checker.sv
// tb_crc_checker: directed scoreboard bench for crc_checker with
// PAYLOAD_BYTES=1 (dut a) and PAYLOAD_BYTES=9 (dut b).
module tb_crc_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_in = 0, a_dv = 0, a_fs = 0;
  logic [7:0] a_byte;
  logic       a_bv, a_ok, a_err, a_ab, a_busy;
  logic       b_in = 0, b_dv = 0, b_fs = 0;
  logic [7:0] b_byte;
  logic       b_bv, b_ok, b_err, b_ab, b_busy;
`ifdef CRC_CHECKER_ERR_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int a_aborts = 0;
  int b_aborts = 0;

  logic [7:0] qa_byte[$];
  logic [7:0] qb_byte[$];
  logic [1:0] qa_st[$];
  logic [1:0] qb_st[$];

  localparam logic [1:0] ST_OK  = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b01;

  crc_checker #(.PAYLOAD_BYTES(1)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .data_in     (a_in),
    .data_valid  (a_dv),
    .frame_start (a_fs),
    .byte_out    (a_byte),
    .byte_valid  (a_bv),
    .crc_ok      (a_ok),
    .crc_err     (a_err),
    .frame_abort (a_ab),
`ifdef CRC_CHECKER_ERR_CNT_EN
    .busy        (a_busy),
    .err_count   (a_cnt)
`else
    .busy        (a_busy)
`endif
  );

  crc_checker #(.PAYLOAD_BYTES(9)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .data_in     (b_in),
    .data_valid  (b_dv),
    .frame_start (b_fs),
    .byte_out    (b_byte),
    .byte_valid  (b_bv),
    .crc_ok      (b_ok),
    .crc_err     (b_err),
    .frame_abort (b_ab),
`ifdef CRC_CHECKER_ERR_CNT_EN
    .busy        (b_busy),
    .err_count   (b_cnt)
`else
    .busy        (b_busy)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_bv) begin
        chk("a_byte_expected", int'(qa_byte.size() > 0), 1);
        if (qa_byte.size() > 0)
          chk("a_byte", a_byte, qa_byte.pop_front());
      end
      if (a_ok | a_err) begin
        chk("a_st_expected", int'(qa_st.size() > 0), 1);
        if (qa_st.size() > 0)
          chk("a_status", {a_ok, a_err}, qa_st.pop_front());
        chk("a_busy_fall", a_busy, 0);
      end
      if (a_ab) a_aborts++;
      if (b_bv) begin
        chk("b_byte_expected", int'(qb_byte.size() > 0), 1);
        if (qb_byte.size() > 0)
          chk("b_byte", b_byte, qb_byte.pop_front());
      end
      if (b_ok | b_err) begin
        chk("b_st_expected", int'(qb_st.size() > 0), 1);
        if (qb_st.size() > 0)
          chk("b_status", {b_ok, b_err}, qb_st.pop_front());
        chk("b_busy_fall", b_busy, 0);
      end
      if (b_ab) b_aborts++;
    end
  end

  task automatic a_bit(input logic b, input logic fs);
    a_in = b; a_dv = 1'b1; a_fs = fs;
    @(posedge clk); #1;
    a_dv = 1'b0; a_fs = 1'b0;
  endtask

  // Idle cycles; frame_start may toggle with data_valid low.
  task automatic a_idle(input int n, input logic fs_noise);
    repeat (n) begin
      a_fs = fs_noise;
      @(posedge clk); #1;
      a_fs = 1'b0;
    end
  endtask

  task automatic a_frame(input logic [7:0] pay,
                         input logic [7:0] crc,
                         input int gap,
                         input logic [1:0] st);
    logic [15:0] d;
    d = {pay, crc};
    qa_byte.push_back(pay);
    qa_st.push_back(st);
    for (int i = 15; i >= 0; i--) begin
      a_bit(d[i], i == 15);
      if (i > 0) a_idle(gap, 1'b1);
    end
  endtask

  task automatic a_partial(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++)
      a_bit(d[15-i], i == 0);
  endtask

  task automatic b_frame9(input logic [7:0] crc,
                          input logic [1:0] st);
    logic [79:0] d;
    logic [71:0] msg;
    msg = "123456789";
    d = {msg, crc};
    for (int k = 0; k < 9; k++)
      qb_byte.push_back(msg[71-8*k -: 8]);
    qb_st.push_back(st);
    for (int i = 79; i >= 0; i--) begin
      b_in = d[i]; b_dv = 1'b1; b_fs = (i == 79);
      @(posedge clk); #1;
      b_dv = 1'b0; b_fs = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_byte", a_byte, 8'h00);
    chk("rst_a_pulses", {a_bv, a_ok, a_err, a_ab, a_busy}, 0);
    chk("rst_b_pulses", {b_bv, b_ok, b_err, b_ab, b_busy}, 0);
    rst = 1'b0;
    a_idle(2, 1'b1);
    chk("idle_a_busy", a_busy, 0);

    a_frame(8'h01, 8'h07, 0, ST_OK);
    a_idle(3, 1'b0);
    chk("a_byte_hold", a_byte, 8'h01);

    a_frame(8'h01, 8'h07, 2, ST_OK);
    a_idle(3, 1'b0);

    a_partial({8'h5A, 8'h00}, 5);
    chk("a_busy_mid", a_busy, 1);
    a_frame(8'h01, 8'h07, 0, ST_OK);
    a_idle(3, 1'b0);
    chk("a_abort_cnt", a_aborts, 1);

    a_frame(8'h00, 8'h00, 0, ST_OK);
    a_frame(8'h01, 8'h07, 0, ST_OK);
    a_partial({8'h01, 8'h07}, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_a_byte", a_byte, 8'h00);
    chk("mid_rst_a_out", {a_bv, a_ok, a_err, a_ab, a_busy}, 0);
    rst = 1'b0;
    a_idle(3, 1'b0);
    chk("post_rst_busy", a_busy, 0);
    a_frame(8'h01, 8'h07, 0, ST_OK);
    a_frame(8'h01, 8'h08, 0, ST_ERR);
    a_idle(3, 1'b0);

    b_frame9(8'hF4, ST_OK);
    b_in = 1'b0;
    @(posedge clk); #1;
    b_frame9(8'hF5, ST_ERR);
    repeat (4) @(posedge clk);
    #1;

    chk("a_byte_drain", qa_byte.size(), 0);
    chk("a_st_drain", qa_st.size(), 0);
    chk("b_byte_drain", qb_byte.size(), 0);
    chk("b_st_drain", qb_st.size(), 0);
    chk("a_abort_final", a_aborts, 1);
    chk("b_abort_final", b_aborts, 0);
    chk("b_last_byte", b_byte, 8'h39);
`ifdef CRC_CHECKER_ERR_CNT_EN
    chk("a_err_count", a_cnt, 1);
    chk("b_err_count", b_cnt, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
